// File: rtl/wb_io_decoder_pkg.sv
// ---------------------------------------------------------------------------
// wb_io_pkg
// Shared types and constants for the Wishbone IO address decoder:
//   - bus geometry (address, data and byte-select widths)
//   - width of the slave index field taken from the address
//   - decoder state encoding
//   - fixed slot numbers of the IO devices behind the decoder
// ---------------------------------------------------------------------------
package wb_io_pkg;

    localparam int NS_MAX = 8;
    localparam int IDX_W  = 3;
    localparam int ADDR_W = 30;
    localparam int DATA_W = 32;
    localparam int SEL_W  = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        ERR  = 2'd2
    } state_t;

    localparam logic [IDX_W-1:0] SLOT_SEVENSEG = 3'd0;
    localparam logic [IDX_W-1:0] SLOT_LED      = 3'd1;
    localparam logic [IDX_W-1:0] SLOT_SW       = 3'd2;
    localparam logic [IDX_W-1:0] SLOT_TIMER    = 3'd3;

endpackage

// File: rtl/wb_io_decoder_if.sv
// ---------------------------------------------------------------------------
// wb_io_decoder_if
// Pipelined Wishbone B4 master-side bus between the CPU and the IO decoder.
//   cyc, stb, we   : cycle, strobe, write enable (master -> decoder)
//   addr           : word address                (master -> decoder)
//   wdata, sel     : write data, byte selects    (master -> decoder)
//   stall, ack     : flow control / completion   (decoder -> master)
//   err            : one-cycle bus error pulse   (decoder -> master)
//   rdata          : read data                   (decoder -> master)
// Modport master is used by the CPU side, modport slave by the decoder.
// ---------------------------------------------------------------------------
interface wb_io_decoder_if;
    import wb_io_pkg::*;

    logic              cyc;
    logic              stb;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [SEL_W-1:0]  sel;
    logic              stall;
    logic              ack;
    logic              err;
    logic [DATA_W-1:0] rdata;

    modport master (
        output cyc, stb, we, addr, wdata, sel,
        input  stall, ack, err, rdata
    );

    modport slave (
        input  cyc, stb, we, addr, wdata, sel,
        output stall, ack, err, rdata
    );

endinterface

// File: rtl/wb_io_decoder.sv
// ---------------------------------------------------------------------------
// wb_io_decoder
// Pipelined Wishbone B4 1-master / NS-slave address decoder for the IO
// devices. Requests are forwarded combinationally to the slave selected by
// addr[SEL_LSB+:3]; acks and read data come back from the slave that owns
// the outstanding requests. Requests to a different slave are stalled until
// all outstanding ones have returned, which keeps responses in order.
// Unmapped slots and a slave that stays silent for TIMEOUT cycles produce a
// one-cycle bus error.
//
// Ports
//   i_clk, i_reset : clock, synchronous active-high reset
//   bus            : master-side Wishbone bus (slave modport)
//   s_cyc, s_stb   : per-slave cycle / strobe (strobe one-hot or zero)
//   s_we, s_addr,
//   s_wdata, s_sel : shared copies of the master request signals
//   s_ack, s_stall : per-slave ack / stall
//   s_rdata        : per-slave read data, slave k on bits [32k+:32]
// ---------------------------------------------------------------------------
module wb_io_decoder
    import wb_io_pkg::*;
#(
    parameter int NS      = 4,
    parameter int SEL_LSB = 8,
    parameter int MAX_OUT = 4,
    parameter int TIMEOUT = 64
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    wb_io_decoder_if.slave       bus,
    output logic [NS-1:0]        s_cyc,
    output logic [NS-1:0]        s_stb,
    output logic                 s_we,
    output logic [ADDR_W-1:0]    s_addr,
    output logic [DATA_W-1:0]    s_wdata,
    output logic [SEL_W-1:0]     s_sel,
    input  logic [NS-1:0]        s_ack,
    input  logic [NS-1:0]        s_stall,
    input  logic [NS*DATA_W-1:0] s_rdata
);

    localparam int CW = $clog2(MAX_OUT + 1);
    localparam int TW = $clog2(TIMEOUT);
    localparam logic [IDX_W:0]  NS_L      = IDX_W'(0) + (IDX_W+1)'(NS);
    localparam logic [CW-1:0]   OUT_FULL  = CW'(MAX_OUT);
    localparam logic [TW-1:0]   WD_LAST   = TW'(TIMEOUT - 1);

    state_t            state, state_next;
    logic [CW-1:0]     outstanding, outstanding_next, count_next;
    logic [TW-1:0]     watchdog, watchdog_next;
    logic [IDX_W-1:0]  cur_slave, cur_slave_next;

    logic [IDX_W-1:0]  idx;
    logic              mapped;
    logic              busy;
    logic              block;
    logic              req;
    logic              accept;
    logic              map_accept;
    logic              ack;
    logic              sel_stall;
    logic              sel_ack;
    logic [DATA_W-1:0] sel_rdata;

    assign idx    = bus.addr[SEL_LSB +: IDX_W];
    assign mapped = ({1'b0, idx} < NS_L);
    assign busy   = (outstanding != '0);
    assign req    = bus.cyc & bus.stb;

    // Pick the stall of the addressed slave and the ack/data of the slave
    // that owns the outstanding requests; out-of-range slots read as zero.
    always_comb begin
        sel_stall = 1'b0;
        sel_ack   = 1'b0;
        sel_rdata = '0;
        for (int k = 0; k < NS; k++) begin
            if (IDX_W'(k) == idx) begin
                sel_stall = s_stall[k];
            end
            if (IDX_W'(k) == cur_slave) begin
                sel_ack   = s_ack[k];
                sel_rdata = s_rdata[DATA_W*k +: DATA_W];
            end
        end
    end

    // A new request may only target the slave already owning outstanding
    // requests, so responses can never come back out of order.
    assign block = (busy && (idx != cur_slave)) || (outstanding == OUT_FULL)
                 || (state == ERR);

    assign bus.stall = i_reset | block | (mapped & sel_stall) | (!mapped & busy);

    assign accept     = req & !bus.stall;
    assign map_accept = accept & mapped;

    assign ack       = bus.cyc & !i_reset & (state == BUSY) & busy & sel_ack;
    assign bus.ack   = ack;
    assign bus.err   = !i_reset & (state == ERR);
    assign bus.rdata = i_reset ? '0 : sel_rdata;

    assign s_we    = !i_reset & bus.we;
    assign s_addr  = i_reset ? '0 : bus.addr;
    assign s_wdata = i_reset ? '0 : bus.wdata;
    assign s_sel   = i_reset ? '0 : bus.sel;

    // Slave cycle follows the owner of outstanding requests, otherwise the
    // addressed slot; it is dropped at once on reset and during an error.
    always_comb begin
        s_cyc = '0;
        s_stb = '0;
        for (int k = 0; k < NS; k++) begin
            if (bus.cyc && !i_reset && (state != ERR)) begin
                s_cyc[k] = busy ? (cur_slave == IDX_W'(k)) : (idx == IDX_W'(k));
            end
            s_stb[k] = req & !i_reset & mapped & !block & (idx == IDX_W'(k));
        end
    end

    // Outstanding count after this cycle's accept and ack.
    always_comb begin
        count_next = outstanding;
        if (map_accept && !ack) begin
            count_next = outstanding + CW'(1);
        end else if (!map_accept && ack) begin
            count_next = outstanding - CW'(1);
        end
    end

    // Next-state logic. Dropping cyc aborts everything without an error.
    // An ack or accept in the watchdog's last cycle still counts as progress.
    always_comb begin
        state_next       = state;
        outstanding_next = outstanding;
        watchdog_next    = watchdog;
        cur_slave_next   = cur_slave;
        if (map_accept) begin
            cur_slave_next = idx;
        end
        if (!bus.cyc) begin
            state_next       = IDLE;
            outstanding_next = '0;
            watchdog_next    = '0;
        end else begin
            case (state)
                IDLE: begin
                    outstanding_next = count_next;
                    watchdog_next    = '0;
                    if (accept) begin
                        state_next = mapped ? BUSY : ERR;
                    end
                end
                BUSY: begin
                    outstanding_next = count_next;
                    if (count_next == '0) begin
                        state_next    = IDLE;
                        watchdog_next = '0;
                    end else if (ack || accept) begin
                        watchdog_next = '0;
                    end else if (watchdog == WD_LAST) begin
                        state_next    = ERR;
                        watchdog_next = '0;
                    end else begin
                        watchdog_next = watchdog + TW'(1);
                    end
                end
                ERR: begin
                    state_next       = IDLE;
                    outstanding_next = '0;
                    watchdog_next    = '0;
                end
                default: begin
                    state_next       = IDLE;
                    outstanding_next = '0;
                    watchdog_next    = '0;
                end
            endcase
        end
    end

    // State, counters and current-slave register.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state       <= IDLE;
            outstanding <= '0;
            watchdog    <= '0;
            cur_slave   <= '0;
        end else begin
            state       <= state_next;
            outstanding <= outstanding_next;
            watchdog    <= watchdog_next;
            cur_slave   <= cur_slave_next;
        end
    end

endmodule
